// File: rtl/clkdiv_2_3_ctrl_if.sv
// Settings/handshake bundle between a ratio programmer and the 2/3 modulus controller.
// The controller side reads m/k/ld and returns rdy plus the registered prescaler controls.
interface clkdiv_2_3_ctrl_if #(
  parameter int W = 8
);
  logic [W-1:0] m;
  logic [W-1:0] k;
  logic         ld;
  logic         rdy;
  logic         sel;
  logic         frame;

  modport master (output m, k, ld, input  rdy, sel, frame);
  modport slave  (input  m, k, ld, output rdy, sel, frame);
endinterface

// File: rtl/clkdiv_2_3_ctrl.sv
// Modulus controller for a by-2/by-3 prescaler: N = 2*M + K over a frame of M output periods.
// A first-order accumulator spreads the K divide-by-3 periods evenly across the frame.
module clkdiv_2_3_ctrl #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  clkdiv_2_3_ctrl_if.slave  bus
);

  logic [W-1:0] m_a_q, m_a_d, k_a_q, k_a_d;
  logic [W-1:0] m_p_q, m_p_d, k_p_q, k_p_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   acc_q, acc_d;
  logic         pend_q, pend_d;
  logic         sel_q, sel_d;
  logic         frame_q, frame_d;

  logic [W:0]   sum;
  logic [W:0]   acc_nxt;
  logic         s;
  logic         wrap;
  logic         idle;

  // acc < m_a and k_a <= m_a, so the sum always fits in W+1 bits.
  always_comb begin
    sum     = acc_q + {1'b0, k_a_q};
    s       = (sum >= {1'b0, m_a_q});
    acc_nxt = sum - (s ? {1'b0, m_a_q} : '0);
    idle    = (m_a_q == '0);
    wrap    = (cnt_q == (m_a_q - W'(1)));
  end

  always_comb begin
    m_a_d   = m_a_q;
    k_a_d   = k_a_q;
    m_p_d   = m_p_q;
    k_p_d   = k_p_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pend_d  = pend_q;
    sel_d   = sel_q;
    frame_d = frame_q;

    if (bus.ld) begin
      m_p_d  = bus.m;
      k_p_d  = (bus.k > bus.m) ? bus.m : bus.k;
      pend_d = 1'b1;
    end

    if (idle) begin
      sel_d   = 1'b0;
      frame_d = 1'b0;
    end else begin
      sel_d   = s;
      frame_d = (cnt_q == '0);
      acc_d   = acc_nxt;
      cnt_d   = cnt_q + W'(1);
      if (wrap) begin
        cnt_d = '0;
        acc_d = '0;
      end
    end

    // Reload only between frames; a same-edge ld keeps the new values pending.
    if (pend_q && (idle || wrap)) begin
      m_a_d  = m_p_q;
      k_a_d  = k_p_q;
      cnt_d  = '0;
      acc_d  = '0;
      pend_d = bus.ld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a_q   <= '0;
      k_a_q   <= '0;
      m_p_q   <= '0;
      k_p_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      pend_q  <= 1'b0;
      sel_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      m_a_q   <= m_a_d;
      k_a_q   <= k_a_d;
      m_p_q   <= m_p_d;
      k_p_q   <= k_p_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
    end
  end

  assign bus.rdy   = ~pend_q;
  assign bus.sel   = sel_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_clkdiv_2_3_ctrl.sv
// Directed bench for the 2/3 modulus controller: sel/frame sequences, reload timing, reset.
module tb_clkdiv_2_3_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  clkdiv_2_3_ctrl_if #(.W(8)) bus ();

  clkdiv_2_3_ctrl #(.W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ld(input logic [7:0] mv, input logic [7:0] kv);
    bus.m  = mv;
    bus.k  = kv;
    bus.ld = 1'b1;
    tick();
    bus.ld = 1'b0;
  endtask

  // Reset pulse, load, and the idle-apply edge: the next tick emits frame position 0.
  task automatic start(input logic [7:0] mv, input logic [7:0] kv);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    do_ld(mv, kv);
    tick();
  endtask

  // Run n periods of a frame of length mm and compare sel against pat (bit i = position i).
  task automatic run_frames(input string tag, input int mm, input logic [31:0] pat, input int n,
                            output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_sel"},   32'(bus.sel),   32'(pat[i % mm]));
      chk({tag, "_frame"}, 32'(bus.frame), 32'((i % mm) == 0));
      if (i < mm) ones += int'(bus.sel);
    end
  endtask

  initial begin
    logic [31:0] pat;
    int ones;
    n_chk  = 0;
    n_err  = 0;
    bus.m  = '0;
    bus.k  = '0;
    bus.ld = 1'b0;
    rst_n  = 1'b0;
    #3;
    chk("rst_sel",   32'(bus.sel),   32'd0);
    chk("rst_frame", 32'(bus.frame), 32'd0);
    chk("rst_rdy",   32'(bus.rdy),   32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_sel", 32'(bus.sel), 32'd0);

    // m=4,k=1: rdy low for exactly one cycle, then 0,0,0,1 with N=9.
    do_ld(8'd4, 8'd1);
    chk("m4_rdy_lo", 32'(bus.rdy), 32'd0);
    tick();
    chk("m4_rdy_hi", 32'(bus.rdy), 32'd1);
    chk("m4_sel_pre", 32'(bus.sel), 32'd0);
    pat = 32'b1000;
    run_frames("m4k1", 4, pat, 8, ones);
    chk("m4k1_ratio", 32'(2 * 4 + ones), 32'd9);

    // m=5,k=2: 0,0,1,0,1 with two ones per frame, N=12.
    start(8'd5, 8'd2);
    pat = 32'b10100;
    run_frames("m5k2", 5, pat, 10, ones);
    chk("m5k2_ones",  32'(ones), 32'd2);
    chk("m5k2_ratio", 32'(2 * 5 + ones), 32'd12);

    // k clamps to m: all ones; k=0: all zeros.
    start(8'd3, 8'd5);
    pat = 32'b111;
    run_frames("m3k5", 3, pat, 6, ones);
    start(8'd3, 8'd0);
    pat = 32'b000;
    run_frames("m3k0", 3, pat, 6, ones);

    // m=1: every period is position 0.
    start(8'd1, 8'd7);
    pat = 32'b1;
    run_frames("m1k1", 1, pat, 3, ones);

    // Mid-frame reload at position 1 of m=4,k=1 -> m=2,k=1 after the wrap.
    start(8'd4, 8'd1);
    tick();
    chk("rl_p0_frame", 32'(bus.frame), 32'd1);
    do_ld(8'd2, 8'd1);
    chk("rl_p1_sel", 32'(bus.sel), 32'd0);
    chk("rl_p1_rdy", 32'(bus.rdy), 32'd0);
    tick();
    chk("rl_p2_sel", 32'(bus.sel), 32'd0);
    chk("rl_p2_rdy", 32'(bus.rdy), 32'd0);
    tick();
    chk("rl_p3_sel", 32'(bus.sel), 32'd1);
    chk("rl_p3_rdy", 32'(bus.rdy), 32'd1);
    pat = 32'b10;
    run_frames("rl_m2k1", 2, pat, 4, ones);

    // Back-to-back loads before the wrap: only the last one lands.
    start(8'd4, 8'd1);
    tick();
    do_ld(8'd6, 8'd3);
    do_ld(8'd7, 8'd0);
    tick();
    chk("b2b_p3_sel", 32'(bus.sel), 32'd1);
    pat = 32'b0;
    run_frames("b2b_m7k0", 7, pat, 14, ones);

    // ld on the wrap edge: old pending applied, new captured, rdy stays low.
    start(8'd4, 8'd1);
    tick();
    do_ld(8'd2, 8'd1);
    tick();
    do_ld(8'd3, 8'd3);
    chk("sim_wrap_sel", 32'(bus.sel), 32'd1);
    chk("sim_rdy", 32'(bus.rdy), 32'd0);
    pat = 32'b10;
    run_frames("sim_m2k1", 2, pat, 2, ones);
    chk("sim_rdy_after", 32'(bus.rdy), 32'd1);
    pat = 32'b111;
    run_frames("sim_m3k3", 3, pat, 3, ones);

    // Loading m=0 takes the block idle at the next wrap.
    do_ld(8'd0, 8'd0);
    chk("go_idle_frame", 32'(bus.frame), 32'd1);
    tick();
    tick();
    pat = 32'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle0_sel",   32'(bus.sel),   32'd0);
      chk("idle0_frame", 32'(bus.frame), 32'd0);
    end

    // Async reset at position 2 of m=5,k=2 with a load pending.
    start(8'd5, 8'd2);
    tick();
    tick();
    do_ld(8'd3, 8'd1);
    chk("ar_p2_sel", 32'(bus.sel), 32'd1);
    chk("ar_p2_rdy", 32'(bus.rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("ar_sel",   32'(bus.sel),   32'd0);
    chk("ar_frame", 32'(bus.frame), 32'd0);
    chk("ar_rdy",   32'(bus.rdy),   32'd1);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ar_idle_sel",   32'(bus.sel),   32'd0);
      chk("ar_idle_frame", 32'(bus.frame), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/clkdiv_2_3_ctrl.md
Name: clkdiv_2_3_ctrl

Overview:
- Modulus controller that drives the sel input of a by-2/by-3 prescaler stage. The result is an arbitrary integer division ratio N = 2*M + K over a frame of M prescaler output periods.
- Clocked by the prescaler output itself and returns one sel decision per output period.
- Spreads the K divide-by-3 periods evenly across the frame with a first-order (Bresenham) accumulator, which minimises phase wander.
- Settings reload is double-buffered and takes effect only on a frame boundary.

Parameters:
W  8  width of frame length m and swallow count k; the largest ratio is 2*(2^W-1)+(2^W-1)

Ports:
clk    input   1  prescaler output; all logic on posedge
rst_n  input   1  asynchronous active-low reset
m      input   W  frame length in prescaler periods; 0 = idle (constant divide-by-2)
k      input   W  number of divide-by-3 periods per frame; clamped to m
ld     input   1  capture m,k into pending registers at this posedge
rdy    output  1  high when no pending settings are waiting
sel    output  1  registered divide select to prescaler (1 = divide by 3)
frame  output  1  registered; high during the period carrying frame position 0

Behaviour:
- Reset (async, rst_n low):
  - sel=0, frame=0, rdy=1.
  - Active regs m_a=0, k_a=0; pending regs cleared; cnt=0, acc=0 (acc is W+1 bits).
  - Release is synchronous to the next posedge. Reset mid-frame abandons the frame immediately and sel drops to 0 asynchronously.
- Outputs are registered only, so there are no glitches on sel. Each clk period carries exactly one sel value, which the prescaler consumes for its following cycle.
- Load:
  - ld=1 at a posedge: m_p<=m, k_p<=min(k,m), pend<=1.
  - rdy = ~pend (combinational from the flop).
  - ld while pend=1 overwrites the pending values (last write wins).
- Idle (m_a==0):
  - Each posedge: sel<=0, frame<=0.
  - If pend=1: m_a<=m_p, k_a<=k_p, cnt<=0, acc<=0, pend<=0.
  - The first sel of the new frame is emitted at the following posedge. From ld to first active sel is 2 posedges.
- Active (m_a>0), each posedge:
  - s = (acc + k_a >= m_a)
  - sel <= s
  - frame <= (cnt==0)
  - acc <= acc + k_a - (s ? m_a : 0)
  - cnt <= cnt+1
- Wrap (cnt == m_a-1 at a posedge): the last sel of the frame is emitted as above, cnt<=0 and acc<=0.
  - If pend=1: m_a,k_a<=m_p,k_p and pend<=0. The new settings drive the next frame's first sel.
  - If m_p==0: the block goes idle.
- Invariants:
  - Exactly k_a ones per frame; acc returns to 0 at each wrap, so the explicit clear only matters after a reload.
  - k_a==m_a gives all ones (divide by 3 throughout). k_a==0 gives all zeros.
  - m_a==1 means every period is position 0: frame stays high and sel=(k_a==1).
- Simultaneous ld and application at the same posedge: the old pending values are applied, the new values are captured, and pend stays 1.
- Arithmetic: acc + k_a is computed in W+1 bits with no overflow, since acc < m_a and k_a <= m_a.

Test Plan:
- Reset then m=4,k=1,ld pulse:
  - rdy low for 1 cycle.
  - sel sequence 0,0,0,1 repeating; frame high on the first of each 4.
  - Period ratio of the prescaler input to clk frame = 9.
- m=5,k=2: sel = 0,0,1,0,1 repeating; exactly 2 ones per frame; N=12.
- m=3,k=5 (clamp): sel constantly 1; m=3,k=0: sel constantly 0; frame every 3rd period in both cases.
- Reload mid-frame: running m=4,k=1; ld m=2,k=1 at frame position 1.
  - rdy stays low until the wrap posedge.
  - Positions 2,3 still emit 0,1; then 0,1 repeating begins.
- Back-to-back ld (m=6,k=3 then m=7,k=0 before the wrap): only m=7,k=0 is applied; sel all 0; frame every 7th period.
- Assert rst_n low at frame position 2 of m=5,k=2:
  - sel and frame go 0 immediately; rdy goes 1.
  - After release the block stays idle (sel=0) until the next ld.
